// File: rtl/command_queue_if.sv
// rtl/command_queue_if.sv - command issue bus between command_queue and the core
//
// Purpose: groups the valid/ready command issue handshake and its payload.
// Signals:
//   out_valid  head entry present (driven by the queue)
//   out_ready  consumer accepts the head this cycle (driven by the core)
//   out_kind   head command kind
//   out_op1    head operand1
//   out_op2    head operand2
// Modports: master = queue side, slave = core side.
interface command_queue_if #(
  parameter int KIND_W = 3,
  parameter int OP1_W  = 4,
  parameter int OP2_W  = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [KIND_W-1:0] out_kind;
  logic [OP1_W-1:0]  out_op1;
  logic [OP2_W-1:0]  out_op2;

  modport master (
    output out_valid,
    output out_kind,
    output out_op1,
    output out_op2,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_kind,
    input  out_op1,
    input  out_op2,
    output out_ready
  );
endinterface

// File: rtl/command_queue.sv
// rtl/command_queue.sv - strobe-captured command FIFO feeding the core issue port
//
// Purpose: samples the pin-level command bundle on each 0->1 edge of in_strobe_i,
// discards NOP (kind 0) commands, buffers the rest in a DEPTH-entry circular FIFO
// and issues them over a valid/ready handshake. Reports occupancy and a sticky
// overflow flag for commands dropped while full.
// Optional feature: define CMD_QUEUE_SYNC_EN to pass in_strobe_i through a 2-flop
// synchronizer (command fields delayed to match, 3-cycle enqueue latency).
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   in_strobe_i  raw command strobe, each rising edge enqueues one command
//   in_kind_i    command kind at strobe
//   in_op1_i     operand1 at strobe
//   in_op2_i     operand2 at strobe
//   ovf_clr_i    synchronous clear of overflow_o
//   cmd_if       issue bus (master): out_valid/out_ready/out_kind/out_op1/out_op2
//   count_o      current occupancy
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//   overflow_o   sticky: a command was dropped
module command_queue #(
  parameter int DEPTH  = 4,
  parameter int KIND_W = 3,
  parameter int OP1_W  = 4,
  parameter int OP2_W  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_strobe_i,
  input  logic [KIND_W-1:0] in_kind_i,
  input  logic [OP1_W-1:0]  in_op1_i,
  input  logic [OP2_W-1:0]  in_op2_i,
  input  logic              ovf_clr_i,
  command_queue_if.master   cmd_if,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam int ENTRY_W = KIND_W + OP1_W + OP2_W;

  logic              strobe_s;
  logic [KIND_W-1:0] kind_s;
  logic [OP1_W-1:0]  op1_s;
  logic [OP2_W-1:0]  op2_s;

`ifdef CMD_QUEUE_SYNC_EN
  // Strobe synchronizer resets high so a strobe already high at reset release
  // is seen as level, not as an edge. Command fields ride a matching delay.
  logic              sync1_q, sync2_q;
  logic [KIND_W-1:0] kind1_q, kind2_q;
  logic [OP1_W-1:0]  op1_1_q, op1_2_q;
  logic [OP2_W-1:0]  op2_1_q, op2_2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      kind1_q <= '0;
      kind2_q <= '0;
      op1_1_q <= '0;
      op1_2_q <= '0;
      op2_1_q <= '0;
      op2_2_q <= '0;
    end else begin
      sync1_q <= in_strobe_i;
      sync2_q <= sync1_q;
      kind1_q <= in_kind_i;
      kind2_q <= kind1_q;
      op1_1_q <= in_op1_i;
      op1_2_q <= op1_1_q;
      op2_1_q <= in_op2_i;
      op2_2_q <= op2_1_q;
    end
  end

  assign strobe_s = sync2_q;
  assign kind_s   = kind2_q;
  assign op1_s    = op1_2_q;
  assign op2_s    = op2_2_q;
`else
  assign strobe_s = in_strobe_i;
  assign kind_s   = in_kind_i;
  assign op1_s    = in_op1_i;
  assign op2_s    = in_op2_i;
`endif

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic             strobe_q, strobe_d;
  logic             arm_q, arm_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic push_req, is_cmd, pop, push, drop;
  logic full_w, empty_w;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // strobe_q resets to 0, so the first cycle after reset would look like a
  // rising edge for a strobe held high. arm_q masks that cycle.
  assign push_req = strobe_s & ~strobe_q & arm_q;
  assign is_cmd   = (kind_s != '0);
  assign pop      = ~empty_w & cmd_if.out_ready;
  // A pop in the same cycle frees the head slot, so a full queue still accepts.
  assign push     = push_req & is_cmd & (~full_w | pop);
  assign drop     = push_req & is_cmd & full_w & ~pop;

  always_comb begin
    strobe_d   = strobe_s;
    arm_d      = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push & ~pop)      count_d = count_q + CNT_W'(1);
    else if (pop & ~push) count_d = count_q - CNT_W'(1);

    // A drop in the clearing cycle takes priority.
    if (drop)           overflow_d = 1'b1;
    else if (ovf_clr_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q   <= 1'b0;
      arm_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q   <= strobe_d;
      arm_q      <= arm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; out_* are meaningful only while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {kind_s, op1_s, op2_s};
  end

  logic [ENTRY_W-1:0] head;
  assign head = mem_q[rd_ptr_q];

  assign cmd_if.out_valid = ~empty_w;
  assign cmd_if.out_kind  = head[ENTRY_W-1 -: KIND_W];
  assign cmd_if.out_op1   = head[OP2_W +: OP1_W];
  assign cmd_if.out_op2   = head[OP2_W-1:0];

  assign count_o    = count_q;
  assign full_o     = full_w;
  assign empty_o    = empty_w;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_command_queue.sv
// tb/tb_command_queue.sv - directed self-checking bench for command_queue
//
// Purpose: drives strobe-captured commands and the issue handshake with
// hand-computed expectations; prints one summary line.
module tb_command_queue;

  localparam int DEPTH = 4;
`ifdef CMD_QUEUE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       in_strobe;
  logic [2:0] in_kind;
  logic [3:0] in_op1;
  logic [7:0] in_op2;
  logic       ovf_clr;
  logic [2:0] count;
  logic       full, empty, overflow;

  int n_chk;
  int n_pass;

  command_queue_if #(.KIND_W(3), .OP1_W(4), .OP2_W(8)) cmd_if ();

  command_queue #(.DEPTH(DEPTH), .KIND_W(3), .OP1_W(4), .OP2_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_strobe_i (in_strobe),
    .in_kind_i   (in_kind),
    .in_op1_i    (in_op1),
    .in_op2_i    (in_op2),
    .ovf_clr_i   (ovf_clr),
    .cmd_if      (cmd_if.master),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Strobe high for one cycle, then wait until the command is in the queue.
  task automatic pulse(input logic [2:0] k, input logic [3:0] a, input logic [7:0] b);
    @(negedge clk);
    in_kind   = k;
    in_op1    = a;
    in_op2    = b;
    in_strobe = 1'b1;
    @(negedge clk);
    in_strobe = 1'b0;
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    cmd_if.out_ready = 1'b1;
    @(negedge clk);
    cmd_if.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [2:0] exp_k [4];
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    in_strobe = 1'b0;
    in_kind = '0;
    in_op1 = '0;
    in_op2 = '0;
    ovf_clr = 1'b0;
    cmd_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_valid", {31'b0, cmd_if.out_valid}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);

    // Single command with latency measurement.
    in_kind = 3'd2;
    in_op1 = 4'h5;
    in_op2 = 8'hA3;
    in_strobe = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_strobe = 1'b0;
      lat++;
      if (cmd_if.out_valid) break;
    end
    chk("latency", lat, LAT);
    chk("t1_kind", {29'b0, cmd_if.out_kind}, 32'd2);
    chk("t1_op1", {28'b0, cmd_if.out_op1}, 32'h5);
    chk("t1_op2", {24'b0, cmd_if.out_op2}, 32'hA3);
    chk("t1_count", {29'b0, count}, 32'd1);
    chk("t1_empty", {31'b0, empty}, 32'd0);
    pop_one();
    chk("t1_drained", {29'b0, count}, 32'd0);

    // Fill to full, then overflow.
    for (int k = 1; k <= 4; k++) pulse(3'(k), 4'(k), 8'(8'h10 + k));
    chk("t2_full", {31'b0, full}, 32'd1);
    chk("t2_count", {29'b0, count}, 32'd4);
    chk("t2_ovf0", {31'b0, overflow}, 32'd0);
    pulse(3'd6, 4'h6, 8'h16);
    chk("t2_ovf1", {31'b0, overflow}, 32'd1);
    chk("t2_count_hold", {29'b0, count}, 32'd4);
    chk("t2_head", {29'b0, cmd_if.out_kind}, 32'd1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", {31'b0, overflow}, 32'd0);

    // Full queue: push of kind 5 lands in the cycle the head is popped.
    @(negedge clk);
    in_kind = 3'd5;
    in_op1 = 4'h5;
    in_op2 = 8'h15;
    in_strobe = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    cmd_if.out_ready = 1'b1;
    @(negedge clk);
    cmd_if.out_ready = 1'b0;
    in_strobe = 1'b0;
    chk("t3_count", {29'b0, count}, 32'd4);
    chk("t3_ovf", {31'b0, overflow}, 32'd0);
    exp_k = '{3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid", {31'b0, cmd_if.out_valid}, 32'd1);
      chk("t3_kind", {29'b0, cmd_if.out_kind}, {29'b0, exp_k[i]});
      chk("t3_op2", {24'b0, cmd_if.out_op2}, 32'h10 + {29'b0, exp_k[i]});
      pop_one();
    end
    chk("t3_empty", {31'b0, empty}, 32'd1);

    // NOP is discarded.
    pulse(3'd0, 4'h9, 8'h99);
    chk("t4_count", {29'b0, count}, 32'd0);
    chk("t4_ovf", {31'b0, overflow}, 32'd0);
    chk("t4_valid", {31'b0, cmd_if.out_valid}, 32'd0);

    // Interleaved push/pop, pointers wrap past DEPTH.
    for (int i = 0; i < 6; i++) begin
      pulse(3'(i % 7 + 1), 4'(i + 8), 8'(8'hC0 + i));
      chk("t5_kind", {29'b0, cmd_if.out_kind}, 32'(i % 7 + 1));
      chk("t5_op1", {28'b0, cmd_if.out_op1}, 32'(i + 8));
      chk("t5_op2", {24'b0, cmd_if.out_op2}, 32'(8'hC0 + i));
      pop_one();
    end
    chk("t5_count", {29'b0, count}, 32'd0);
    chk("t5_empty", {31'b0, empty}, 32'd1);

    // Strobe held high through reset release does not enqueue.
    @(negedge clk);
    in_kind = 3'd7;
    in_strobe = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_count", {29'b0, count}, 32'd0);
    chk("t6_valid", {31'b0, cmd_if.out_valid}, 32'd0);
    in_strobe = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
